timer_multi: RTL and testbench

TIMER_MULTI -- requirements
Module: timer_multi

---
 rtl/timer_multi.sv | 183 ++++++++++++++++++
 tb/tb_timer_multi.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_multi.sv
// timer_multi: bank of independent down-counting timers behind an 8-bit
// register bus. Each channel has a prescaler, a reload register, a coherent
// read shadow and a sticky expiry flag. Read data is registered (one cycle).

// One timer channel: registers, prescaler, counter and channel read mux.
module timer_multi_chan #(
    parameter int WIDTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_wr,
    input  logic       i_rd,
    input  logic [2:0] i_off,
    input  logic [7:0] i_dbw,
    output logic [7:0] o_rdata,
    output logic       o_irq
);
    localparam int NB = WIDTH / 8;

    logic [WIDTH-1:0] r_cnt, r_reload, r_shadow;
    logic [7:0]       r_pc, r_p;
    logic             r_act, r_cont, r_ien, r_shot;

    logic [WIDTH-1:0] w_cnt_nx, w_reload_nx, w_view;
    logic [7:0]       w_pc_nx;
    logic             w_act_nx, w_shot_nx;
    logic             w_wr_ctrl, w_wr_p, w_tick, w_exp, w_load;

    assign w_wr_ctrl = i_wr && (i_off == 3'd4);
    assign w_wr_p    = i_wr && (i_off == 3'd5);
    assign w_tick    = r_act && (r_pc == r_p);
    assign w_exp     = w_tick && (r_cnt == '0);
    assign w_load    = w_wr_ctrl && i_dbw[3];
    assign o_irq     = r_shot && r_ien;

    // Byte 0 reads the live counter; upper bytes come from the shadow
    // captured by the byte-0 read, so multi-byte reads are coherent.
    assign w_view = (r_shadow & ~WIDTH'(8'hFF)) | WIDTH'(r_cnt[7:0]);

    // Next-state: bus writes override timer activity where they collide,
    // except that an expiry always sets shot.
    always_comb begin
        w_reload_nx = r_reload;
        for (int n = 0; n < NB; n++)
            if (i_wr && (i_off == 3'(n)))
                w_reload_nx[n*8 +: 8] = i_dbw;

        w_pc_nx = r_pc;
        if (w_load || w_tick || (w_wr_ctrl && i_dbw[0] && !r_act))
            w_pc_nx = 8'h00;
        else if (r_act)
            w_pc_nx = r_pc + 8'd1;

        // Expiry reload uses the pre-write reload value.
        w_cnt_nx = r_cnt;
        if (w_load)
            w_cnt_nx = w_reload_nx;
        else if (w_tick) begin
            if (r_cnt != '0)
                w_cnt_nx = r_cnt - WIDTH'(1);
            else if (r_cont)
                w_cnt_nx = r_reload;
        end

        w_act_nx = r_act;
        if (w_wr_ctrl)
            w_act_nx = i_dbw[0];
        else if (w_exp && !r_cont)
            w_act_nx = 1'b0;

        w_shot_nx = r_shot;
        if (w_exp)
            w_shot_nx = 1'b1;
        else if (w_wr_ctrl && i_dbw[7])
            w_shot_nx = 1'b0;
    end

    // Channel register read mux (unmapped bytes and offsets read 0).
    always_comb begin
        o_rdata = 8'h00;
        for (int n = 0; n < NB; n++)
            if (i_off == 3'(n))
                o_rdata = w_view[n*8 +: 8];
        if (i_off == 3'd4)
            o_rdata = {r_shot, 3'b000, 1'b0, r_ien, r_cont, r_act};
        if (i_off == 3'd5)
            o_rdata = r_p;
    end

    // Channel state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt    <= '0;
            r_reload <= '0;
            r_shadow <= '0;
            r_pc     <= 8'h00;
            r_p      <= 8'h00;
            r_act    <= 1'b0;
            r_cont   <= 1'b0;
            r_ien    <= 1'b0;
            r_shot   <= 1'b0;
        end else begin
            r_cnt    <= w_cnt_nx;
            r_reload <= w_reload_nx;
            r_pc     <= w_pc_nx;
            r_act    <= w_act_nx;
            r_shot   <= w_shot_nx;
            if (w_wr_ctrl) begin
                r_cont <= i_dbw[1];
                r_ien  <= i_dbw[2];
            end
            if (w_wr_p)
                r_p <= i_dbw;
            if (i_rd && (i_off == 3'd0))
                r_shadow <= r_cnt;
        end
    end
endmodule

module timer_multi #(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 2,
    parameter int AW       = 4
) (
    input  logic          clk,
    input  logic          rst,
    output logic [7:0]    dbr,
    input  logic [7:0]    dbw,
    input  logic [AW-1:0] addr,
    input  logic          cs,
    input  logic          we,
    output logic          irq
);
    localparam int CW = AW - 3;

    logic [CW-1:0]                w_ch;
    logic [2:0]                   w_off;
    logic                         w_wr, w_rd;
    logic [CHANNELS-1:0][7:0]     w_rdata;
    logic [CHANNELS-1:0]          w_irq;
    logic [7:0]                   w_rsel;
    logic [7:0]                   r_dbr;

    assign w_ch  = addr[AW-1:3];
    assign w_off = addr[2:0];
    assign w_wr  = cs && we;
    assign w_rd  = cs && !we;

    genvar gc;
    generate
        for (gc = 0; gc < CHANNELS; gc++) begin : g_chan
            timer_multi_chan #(.WIDTH(WIDTH)) u_chan (
                .clk     (clk),
                .rst     (rst),
                .i_wr    (w_wr && (w_ch == CW'(gc))),
                .i_rd    (w_rd && (w_ch == CW'(gc))),
                .i_off   (w_off),
                .i_dbw   (dbw),
                .o_rdata (w_rdata[gc]),
                .o_irq   (w_irq[gc])
            );
        end
    endgenerate

    // Channel select for reads; indices beyond CHANNELS fall through to 0.
    always_comb begin
        w_rsel = 8'h00;
        for (int c = 0; c < CHANNELS; c++)
            if (w_ch == CW'(c))
                w_rsel = w_rdata[c];
    end

    // Registered read data, zero on any cycle without a read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_dbr <= 8'h00;
        else
            r_dbr <= w_rd ? w_rsel : 8'h00;
    end

    assign dbr = r_dbr;
    assign irq = |w_irq;
endmodule

// File: tb/tb_timer_multi.sv
// Bench for timer_multi: directed scenarios plus random bus traffic, checked
// by a scoreboard against a behavioural model of the timer channels.
module tb_timer_multi;
    localparam int W  = 16;
    localparam int CH = 3;   // three channels so that index 3 is out of range
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cs = 1'b0, we = 1'b0;
    logic [7:0]    dbw = 8'h00;
    logic [7:0]    dbr;
    logic [AW-1:0] addr = '0;
    logic          irq;

    timer_multi #(.WIDTH(W), .CHANNELS(CH), .AW(AW)) dut (
        .clk(clk), .rst(rst), .dbr(dbr), .dbw(dbw), .addr(addr),
        .cs(cs), .we(we), .irq(irq)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    int unsigned m_cnt[CH], m_rel[CH], m_sh[CH], m_pc[CH], m_p[CH];
    bit          m_act[CH], m_cont[CH], m_ien[CH], m_shot[CH];

    typedef struct {
        logic [7:0] exp;
        bit         dchk;
        logic [7:0] dval;
        string      nm;
    } rd_t;
    rd_t q[$];
    bit  m_rd = 1'b0;

    // directed expectation attached to the read currently on the bus
    bit         d_chk = 1'b0;
    logic [7:0] d_val = 8'h00;
    string      d_nm  = "";

    function automatic logic [7:0] model_read(input int c, input int off);
        int unsigned v;
        if (c >= CH) return 8'h00;
        if (off < 4) begin
            if (off >= W / 8) return 8'h00;
            v = (off == 0) ? m_cnt[c] : m_sh[c];
            return 8'((v >> (8 * off)) & 32'hFF);
        end
        if (off == 4) return {m_shot[c], 3'b000, 1'b0, m_ien[c], m_cont[c], m_act[c]};
        if (off == 5) return 8'(m_p[c]);
        return 8'h00;
    endfunction

    function automatic bit model_irq();
        bit r = 1'b0;
        for (int c = 0; c < CH; c++) r |= m_shot[c] & m_ien[c];
        return r;
    endfunction

    // Advance the model by one clock using the bus op presented this cycle.
    always @(posedge clk or posedge rst) begin
        int  mc, mo;
        bit  tick, ex, wrc, old_act;
        rd_t e;
        if (rst) begin
            for (int c = 0; c < CH; c++) begin
                m_cnt[c] = 0; m_rel[c] = 0; m_sh[c] = 0; m_pc[c] = 0; m_p[c] = 0;
                m_act[c] = 0; m_cont[c] = 0; m_ien[c] = 0; m_shot[c] = 0;
            end
            q.delete();
            m_rd = 1'b0;
        end else begin
            mc = int'(addr[AW-1:3]);
            mo = int'(addr[2:0]);
            m_rd = cs && !we;
            if (m_rd) begin
                e.exp = model_read(mc, mo);
                e.dchk = d_chk; e.dval = d_val; e.nm = d_nm;
                q.push_back(e);
                if (mc < CH && mo == 0) m_sh[mc] = m_cnt[mc];
            end
            for (int c = 0; c < CH; c++) begin
                tick    = m_act[c] && (m_pc[c] == m_p[c]);
                ex      = tick && (m_cnt[c] == 0);
                wrc     = cs && we && (mc == c);
                old_act = m_act[c];
                if (m_act[c]) m_pc[c] = tick ? 0 : (m_pc[c] + 1) % 256;
                if (tick) begin
                    if (m_cnt[c] != 0) m_cnt[c] = m_cnt[c] - 1;
                    else begin
                        m_shot[c] = 1'b1;
                        if (m_cont[c]) m_cnt[c] = m_rel[c];
                        else m_act[c] = 1'b0;
                    end
                end
                if (wrc) begin
                    if (mo < W / 8)
                        m_rel[c] = (m_rel[c] & ~(32'hFF << (8 * mo))) | (32'(dbw) << (8 * mo));
                    else if (mo == 4) begin
                        if (dbw[0] && !old_act) m_pc[c] = 0;
                        m_act[c]  = dbw[0];
                        m_cont[c] = dbw[1];
                        m_ien[c]  = dbw[2];
                        if (dbw[7] && !ex) m_shot[c] = 1'b0;
                        if (dbw[3]) begin m_cnt[c] = m_rel[c]; m_pc[c] = 0; end
                    end else if (mo == 5)
                        m_p[c] = dbw;
                end
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        rd_t e;
        if (rst) begin
            check("rst_dbr", dbr, 0);
            check("rst_irq", irq, 0);
        end else begin
            if (m_rd) begin
                if (q.size() == 0) begin
                    n_chk++;
                    $display("FAIL sb_underflow: read completed with no expectation at %0t", $time);
                end else begin
                    e = q.pop_front();
                    check("rd_model", dbr, e.exp);
                    if (e.dchk) check(e.nm, dbr, e.dval);
                end
            end else
                check("dbr_idle", dbr, 0);
            check("irq_model", irq, model_irq());
        end
    end

    // ---------------- driver ----------------
    task automatic bus(input bit c, input bit w, input int ch, input int off,
                       input logic [7:0] d, input bit dc, input logic [7:0] dv, input string nm);
        @(negedge clk);
        cs = c; we = w; addr = AW'(ch * 8 + off); dbw = d;
        d_chk = dc; d_val = dv; d_nm = nm;
    endtask
    task automatic wr(input int ch, input int off, input logic [7:0] d);
        bus(1, 1, ch, off, d, 0, 8'h00, "");
    endtask
    task automatic rd(input int ch, input int off);
        bus(1, 0, ch, off, 8'h00, 0, 8'h00, "");
    endtask
    task automatic rdx(input int ch, input int off, input logic [7:0] v, input string nm);
        bus(1, 0, ch, off, 8'h00, 1, v, nm);
    endtask
    task automatic idle(input int n);
        repeat (n) bus(0, 0, 0, 0, 8'h00, 0, 8'h00, "");
    endtask
    task automatic pulse_rst();
        @(negedge clk); #2; rst = 1'b1; cs = 1'b0; we = 1'b0;
        repeat (2) @(negedge clk);
        #2; rst = 1'b0;
    endtask

    logic [7:0] ct_tab [14] = '{8'd2, 8'd2, 8'd1, 8'd1, 8'd0, 8'd0,
                                8'd2, 8'd2, 8'd1, 8'd1, 8'd0, 8'd0, 8'd2, 8'd2};

    initial begin
        int r, ch, off;
        logic [7:0] d;
        repeat (3) @(negedge clk);
        #2; rst = 1'b0;

        // reset state
        rdx(0, 4, 8'h00, "rst_ctrl0");
        rdx(1, 0, 8'h00, "rst_cnt1");
        rdx(0, 5, 8'h00, "rst_p0");

        // one-shot on ch0: reload 3, P 0
        wr(0, 0, 8'h03); wr(0, 1, 8'h00); wr(0, 5, 8'h00); wr(0, 4, 8'h0D);
        rdx(0, 0, 8'd3, "os_c3");
        rdx(0, 0, 8'd2, "os_c2");
        rdx(0, 0, 8'd1, "os_c1");
        rdx(0, 0, 8'd0, "os_c0");
        rdx(0, 4, 8'h84, "os_ctrl");
        rdx(0, 0, 8'd0, "os_hold");
        check("os_irq", irq, 1);

        // shot clear colliding with expiry: set wins
        wr(0, 4, 8'h84);
        wr(0, 4, 8'h0D);
        idle(3);
        wr(0, 4, 8'h84);          // lands on the expiry edge
        idle(1);
        check("col_irq", irq, 1);
        rdx(0, 4, 8'h84, "col_ctrl");
        wr(0, 4, 8'h84);
        check("col_irq_pre", irq, 1);
        idle(1);
        check("col_irq_drop", irq, 0);

        // continuous on ch1: reload 2, P 1 -> period 6
        wr(1, 0, 8'h02); wr(1, 1, 8'h00); wr(1, 5, 8'h01); wr(1, 4, 8'h0B);
        for (int i = 0; i < 14; i++) rdx(1, 0, ct_tab[i], $sformatf("ct_cnt%0d", i));
        rdx(1, 4, 8'h83, "ct_ctrl");
        check("ct_irq", irq, 0);
        wr(1, 4, 8'h80);

        // coherent multi-byte read on ch2
        wr(2, 0, 8'h00); wr(2, 1, 8'h01); wr(2, 5, 8'h00); wr(2, 4, 8'h09);
        rdx(2, 0, 8'h00, "coh_lo");
        idle(1);
        rdx(2, 1, 8'h01, "coh_hi");
        wr(2, 4, 8'h00);

        // out-of-range channel and reserved offsets
        wr(0, 5, 8'h22);
        wr(3, 0, 8'hAA); wr(3, 4, 8'h0F); wr(3, 5, 8'h07);
        rdx(3, 0, 8'h00, "oor_cnt");
        rdx(3, 4, 8'h00, "oor_ctrl");
        rdx(3, 5, 8'h00, "oor_p");
        rdx(0, 6, 8'h00, "resv6");
        rdx(0, 2, 8'h00, "byte2");
        rdx(0, 5, 8'h22, "oor_p0");
        rdx(1, 5, 8'h01, "oor_p1");

        // reset mid-count stops the channel
        wr(0, 0, 8'h50); wr(0, 5, 8'h02); wr(0, 4, 8'h0F);
        idle(10);
        pulse_rst();
        for (int o = 0; o < 6; o++) rdx(0, o, 8'h00, $sformatf("mrst_off%0d", o));
        idle(300);
        check("mrst_irq", irq, 0);
        rdx(0, 4, 8'h00, "mrst_ctrl");

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            r   = $urandom_range(0, 199);
            ch  = $urandom_range(0, 3);
            off = $urandom_range(0, 7);
            d   = 8'($urandom);
            if (r < 1) pulse_rst();
            else if (r < 80) idle(1);
            else if (r < 140) rd(ch, off);
            else begin
                case (off)
                    0: d = 8'($urandom_range(0, 20));
                    1: d = 8'($urandom_range(0, 1));
                    4: d = {d[7], 3'b000, ($urandom_range(0, 3) == 0), d[2], d[1],
                            ($urandom_range(0, 3) != 0)};
                    5: d = 8'($urandom_range(0, 3));
                    default: ;
                endcase
                wr(ch, off, d);
            end
        end
        idle(3);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
